// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response and shifter-drive bundle for shift_sequencer
//
// Purpose: groups the controller handshake and the shifter datapath signals.
// Signals:
//   start, op[1:0], amount[3:0], value[15:0] : request from controller
//   busy, done, result[15:0]                 : status/response to controller
//   sh_in[15:0], sh_op[1:0]                  : drive to the external 1-bit shifter
//   sh_out[15:0]                             : combinational return from the shifter
// Modports: master = controller/shifter environment, slave = shift_sequencer.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] sh_in;
  logic [1:0]  sh_op;
  logic [15:0] sh_out;

  modport master (
    output start, op, amount, value, sh_out,
    input  busy, done, result, sh_in, sh_op
  );

  modport slave (
    input  start, op, amount, value, sh_out,
    output busy, done, result, sh_in, sh_op
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle sequencer stepping a 1-bit shifter 0..15 times
//
// Purpose: accepts one shift request, latches it, and loops the operand through
// the external single-bit shifter once per cycle until the count is exhausted.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : shift_sequencer_if.slave (request, status, result, shifter drive)
module shift_sequencer (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'h0000;
      result_q <= 16'h0000;
      op_q     <= 2'b00;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d = bus.value;
          op_d  = bus.op;
          cnt_d = bus.amount;
          // Nothing to shift: the operand itself is the answer.
          if (bus.amount == 4'd0 || bus.op == 2'b00) begin
            state_d  = S_DONE;
            result_d = bus.value;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = bus.sh_out;
        cnt_d = cnt_q - 4'd1;
        // Last step: capture the shifter output directly so result is valid in DONE.
        if (cnt_q == 4'd1) begin
          state_d  = S_DONE;
          result_d = bus.sh_out;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.sh_in  = acc_q;
  // Outside SHIFT the shifter is held in pass mode so it never consumes a step.
  assign bus.sh_op  = (state_q == S_SHIFT) ? op_q : 2'b00;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that drives the datapath's 16-bit single-bit shifter to perform shifts of 0–15 positions. It accepts one request over a start/done handshake, latches the operand, and feeds it back through the shifter once per cycle until the requested count is exhausted. It sits between the control FSM and the shifter: its outputs drive the shifter's `shift_in`/`shift_op`, and it consumes `shift_out`.

## Interface
Parameters:
- none; width is fixed at 16 and amount at 4 bits to match the shifter.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request strobe; sampled only in IDLE.
- `op`  in  2  — shift operation:
  - 00 = pass
  - 01 = left shift, 0 into LSB
  - 10 = logical right shift, 0 into MSB
  - 11 = arithmetic right shift, MSB replicated
- `amount`  in  4  — number of 1-bit shift steps, 0–15.
- `value`  in  16  — operand.
- `busy`  out  1  — high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  — one-cycle completion pulse.
- `result`  out  16  — final shifted value; holds until the next completion.
- `sh_in`  out  16  — drives the shifter's `shift_in`.
- `sh_op`  out  2  — drives the shifter's `shift_op`.
- `sh_out`  in  16  — the shifter's `shift_out`, which is combinational.

## Operation
- Internal state:
  - `acc`, 16-bit working register.
  - `op_q`, 2 bits.
  - `cnt`, 4 bits.
  - FSM with states IDLE, SHIFT, DONE.
- IDLE:
  - `busy`=0, `done`=0.
  - On `start`=1: `acc`<=`value`, `op_q`<=`op`, `cnt`<=`amount`.
  - Next state is DONE if `amount`==0 or `op`==00; otherwise SHIFT.
- SHIFT:
  - `sh_in`=`acc`, `sh_op`=`op_q`.
  - Each cycle: `acc`<=`sh_out`, `cnt`<=`cnt`-1.
  - When `cnt`==1, the same edge moves to DONE.
- DONE:
  - `done`=1, `busy`=1.
  - `result` is loaded from `acc` on the edge entering DONE.
  - Unconditionally returns to IDLE next cycle.
- Outside SHIFT: `sh_in`=`acc`, `sh_op`=00, so the shifter is a pass-through and consumes no step.
- Arithmetic: no carry out. Bits shifted off either end are discarded.
  - Op 11 with `amount`=15 yields all copies of the original MSB.
- Ignored starts:
  - `start` while `busy`=1 (SHIFT or DONE) is ignored and not queued.
  - The first `start` after returning to IDLE is accepted.
- `value`/`op`/`amount` changes after acceptance have no effect on the request in flight.

## Timing
- Reset (synchronous, `reset`=1 at an edge):
  - state=IDLE; `acc`, `result`, `sh_in`=0x0000; `cnt`=0; `op_q`, `sh_op`=00.
  - `busy`=0, `done`=0.
  - Applies in any state. Reset mid-SHIFT aborts the operation: no `done` pulse, and `result` is cleared.
- Reset dominates a simultaneous `start`.
- Latency, with `start` sampled at edge k and N=`amount`, op≠00:
  - SHIFT occupies cycles k+1 … k+N.
  - `done`=1 during cycle k+N+1.
  - `result` is valid from cycle k+N+1.
- Latency for N=0 or op=00: `done`=1 during cycle k+1, with `result`=`value`.
- Throughput: the next `start` is accepted at the edge ending the first IDLE cycle after DONE. Minimum request spacing is N+2 cycles.
- `busy` and `done` are registered (state-decoded). `sh_in`/`sh_op` are combinational from `acc`/state.

## Test plan
- Left shift: `value`=0x0001, op=01, `amount`=4.
  - `busy` high 5 cycles; `sh_op`=01 for exactly 4 cycles.
  - `done` pulse at k+5; `result`=0x0010.
- Right shifts, `value`=0xA455, `amount`=3:
  - op=11 → `result`=0xF48A.
  - op=10 → `result`=0x148A.
  - Both complete at k+4.
- Zero/pass cases:
  - `amount`=0, op=01, `value`=0x1234 → `done` at k+1, `result`=0x1234, `sh_op` never 01.
  - op=00, `amount`=7 → same timing and `result`=`value`.
- Maximum amount: `value`=0xFFFF, op=01, `amount`=15 → `result`=0x8000 at k+16.
  - With op=11, `value`=0x8000 → `result`=0xFFFF.
- Start while busy: assert `start` during SHIFT with a different `value`.
  - Ignored; the original `result` is produced; no second `done`.
- Reset mid-SHIFT: assert `reset` during the 2nd SHIFT cycle.
  - Next cycle: IDLE, `busy`=0, `done`=0, `result`=0x0000.
  - A new request afterwards completes normally.
